// File: rtl/core_db_pkg.sv
`default_nettype none
// ============================================================================
// core_db_pkg : shared widths, FSM state type and the Hamming(7,4) corrector
// Rev 1.0
// ============================================================================
package core_db_pkg;

  localparam int PKT_W = 11;
  localparam int CW_W  = 7;
  localparam int DB_W  = 8;
  localparam int IP_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Returns {corrected codeword, syndrome}; cw[k] is Hamming position k+1.
  function automatic logic [9:0] hamming74_fix(input logic [CW_W-1:0] cw);
    logic [2:0]      syn;
    logic [CW_W-1:0] fix;
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    fix    = cw;
    if (syn != 3'd0) begin
      fix[syn - 3'd1] = ~fix[syn - 3'd1];
    end
    return {fix, syn};
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_db_hamming_dec.sv
`default_nettype none
// ============================================================================
// core_db_hamming_dec : combinational Hamming(7,4) single-error corrector
// Rev 1.0
// ============================================================================
module core_db_hamming_dec
  import core_db_pkg::*;
(
  input  logic [CW_W-1:0] i_cw,
  output logic [3:0]      o_data,
  output logic [2:0]      o_syn
);

  logic [9:0] w_fix;

  assign w_fix  = hamming74_fix(i_cw);
  // Data bits live at positions 7,6,5,3 -> codeword bits 6,5,4,2.
  assign o_data = {w_fix[9], w_fix[8], w_fix[7], w_fix[5]};
  assign o_syn  = w_fix[2:0];

endmodule
`default_nettype wire

// File: rtl/core_db_rr_sched.sv
`default_nettype none
// ============================================================================
// core_db_rr_sched : round-robin scheduler sharing one Hamming(7,4)
//                    corrector and one data-bucket channel among NUM_SRC ports
// Rev 1.0
// ============================================================================
module core_db_rr_sched
  import core_db_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*PKT_W-1:0] in_data,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic                     out_valid,
  output logic [DB_W-1:0]          out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     err_flag,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     busy
);

  localparam int c_IW = SRC_W + 1;

  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_rr_ptr, r_src, w_grant;
  logic [c_IW-1:0]    w_idx;
  logic               w_found, w_acc;
  logic [PKT_W-1:0]   r_pkt;
  logic [3:0]         w_dec_data;
  logic [2:0]         w_dec_syn;
  logic               r_out_valid, r_err_flag;
  logic [DB_W-1:0]    r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [NUM_SRC-1:0] w_ready;

  // Search starts at rr_ptr; the wrap is an explicit compare so that
  // non-power-of-two NUM_SRC never lands on a nonexistent source.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = {1'b0, r_rr_ptr} + c_IW'(k);
      if (w_idx >= c_IW'(NUM_SRC)) begin
        w_idx = w_idx - c_IW'(NUM_SRC);
      end
      if (!w_found && in_valid[w_idx[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == IDLE && w_found) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign w_acc = (r_state == IDLE) && w_found;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = DECODE;
      DECODE:  w_state_nxt = SEND;
      SEND:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  core_db_hamming_dec u_dec (
    .i_cw   (r_pkt[PKT_W-1:IP_W]),
    .o_data (w_dec_data),
    .o_syn  (w_dec_syn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt       <= '0;
      r_src       <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_pkt <= in_data[PKT_W*w_grant +: PKT_W];
            r_src <= w_grant;
          end
        end
        DECODE: begin
          r_out_data  <= {w_dec_data, r_pkt[IP_W-1:0]};
          r_out_src   <= r_src;
          r_err_flag  <= (w_dec_syn != 3'd0);
          r_out_valid <= 1'b1;
          if (w_dec_syn != 3'd0 && r_err_cnt != {CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rr_ptr    <= (r_src == SRC_W'(NUM_SRC - 1)) ? '0 : r_src + SRC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign err_flag  = r_err_flag;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_db_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_core_db_rr_sched : scoreboard bench for core_db_rr_sched
// Rev 1.0
// ============================================================================
module tb_core_db_rr_sched;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int CNT_W   = 8;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_DEC  = 2'd1;
  localparam logic [1:0] M_SEND = 2'd2;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic             err;
    logic [7:0]       data;
  } sb_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_SRC-1:0]            src_valid = '0;
  logic [NUM_SRC-1:0][10:0]      src_pkt = '0;
  logic [NUM_SRC-1:0]            in_ready;
  logic                          out_valid;
  logic [7:0]                    out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          out_ready = 1'b0;
  logic                          err_flag;
  logic [CNT_W-1:0]              err_cnt;
  logic                          busy;

  int n_checks = 0;
  int n_errors = 0;

  int          rem [NUM_SRC];
  int          mode [NUM_SRC];
  logic [10:0] fix_pkt [NUM_SRC];
  logic [NUM_SRC-1:0] acc_seen = '0;

  sb_t         sbq [$];
  logic [1:0]  m_state = M_IDLE;
  logic [SRC_W-1:0] m_rr = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  int          cyc = 0;

  sb_t         log_q [$];
  int          log_cyc [$];

  core_db_rr_sched #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (src_valid),
    .in_data   (src_pkt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference decoder: syndrome is the XOR of the positions of all set bits.
  function automatic logic [8:0] model_dec(input logic [10:0] p);
    logic [2:0] s;
    logic [6:0] c;
    c = p[10:4];
    s = 3'd0;
    for (int k = 0; k < 7; k++) if (c[k]) s = s ^ 3'(k + 1);
    if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
    return {(s != 3'd0), c[6], c[5], c[4], c[2], p[3:0]};
  endfunction

  function automatic logic [10:0] gen_pkt(input int i);
    logic [3:0] d;
    logic [6:0] c;
    case (mode[i])
      1: return fix_pkt[i];
      2: begin
        d = 4'($urandom_range(0, 15));
        c = {d[3], d[2], d[1], d[3] ^ d[2] ^ d[1], d[0],
             d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        c[$urandom_range(0, 6)] ^= 1'b1;
        return {c, 4'($urandom_range(0, 15))};
      end
      default: return 11'($urandom);
    endcase
  endfunction

  always @(negedge clk) acc_seen = src_valid & in_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc_seen[i]) begin
        src_valid[i] = 1'b0;
        rem[i]       = rem[i] - 1;
      end
      if (!src_valid[i] && rem[i] > 0) begin
        src_pkt[i]   = gen_pkt(i);
        src_valid[i] = 1'b1;
      end
    end
    acc_seen = '0;
  end

  // Cycle-accurate reference of the scheduler, evaluated between edges.
  always @(negedge clk) begin
    sb_t         e;
    logic [8:0]  r;
    int          g;
    logic        found;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_rr    = '0;
      m_cnt   = '0;
      sbq.delete();
    end else begin
      check("err_cnt", err_cnt, m_cnt);
      check("busy", busy, m_state != M_IDLE);
      case (m_state)
        M_IDLE: begin
          check("out_valid_idle", out_valid, 0);
          found = 1'b0;
          g     = 0;
          for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (int'(m_rr) + k) % NUM_SRC;
            if (!found && src_valid[idx]) begin
              found = 1'b1;
              g     = idx;
            end
          end
          check("in_ready", in_ready, found ? (32'd1 << g) : 32'd0);
          if (found) begin
            r      = model_dec(src_pkt[g]);
            e.src  = SRC_W'(g);
            e.err  = r[8];
            e.data = r[7:0];
            sbq.push_back(e);
            m_state = M_DEC;
          end
        end
        M_DEC: begin
          check("out_valid_dec", out_valid, 0);
          check("in_ready_dec", in_ready, 0);
          if (sbq.size() > 0 && sbq[0].err && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
          m_state = M_SEND;
        end
        default: begin
          check("out_valid_send", out_valid, 1);
          check("in_ready_send", in_ready, 0);
          check("sb_nonempty", sbq.size(), 1);
          if (sbq.size() > 0) begin
            check("out_data", out_data, sbq[0].data);
            check("out_src", out_src, sbq[0].src);
            check("err_flag", err_flag, sbq[0].err);
            if (out_ready) begin
              e = sbq.pop_front();
              log_q.push_back('{src: out_src, err: err_flag, data: out_data});
              log_cyc.push_back(cyc);
              m_rr    = (int'(e.src) == NUM_SRC - 1) ? '0 : e.src + 1'b1;
              m_state = M_IDLE;
            end
          end
        end
      endcase
    end
  end

  task automatic drain(input int limit);
    logic done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      @(posedge clk);
      #2;
      done = (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 &&
              src_valid == '0 && m_state == M_IDLE && sbq.size() == 0);
    end
    check("drain_timeout", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      rem[i]     = 0;
      mode[i]    = 0;
      fix_pkt[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Clean packet from source 0
    log_q.delete();
    mode[0] = 1; fix_pkt[0] = 11'h553; rem[0] = 1;
    drain(50);
    check("t1_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("t1_data", log_q[0].data, 8'hB3);
      check("t1_src", log_q[0].src, 0);
      check("t1_err", log_q[0].err, 0);
    end
    check("t1_err_cnt", err_cnt, 0);

    // Single-bit error from source 2 (position 5 flipped)
    log_q.delete();
    mode[2] = 1; fix_pkt[2] = 11'h453; rem[2] = 1;
    drain(50);
    check("t2_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("t2_data", log_q[0].data, 8'hB3);
      check("t2_src", log_q[0].src, 2);
      check("t2_err", log_q[0].err, 1);
    end
    check("t2_err_cnt", err_cnt, 1);

    // Fairness with every source continuously valid
    do_reset();
    log_q.delete();
    log_cyc.delete();
    for (int i = 0; i < NUM_SRC; i++) begin
      mode[i] = 0;
      rem[i]  = 2;
    end
    drain(200);
    check("t3_count", log_q.size(), 8);
    for (int j = 0; j < 8 && j < log_q.size(); j++) begin
      check("t3_order", log_q[j].src, j % NUM_SRC);
      if (j > 0) check("t3_spacing", log_cyc[j] - log_cyc[j-1], 3);
    end

    // Backpressure: output held for 10 cycles while another source waits
    out_ready = 1'b0;
    rem[1] = 1; rem[3] = 1;
    for (int n = 0; n < 50 && !out_valid; n++) @(posedge clk);
    check("t4_out_valid_seen", out_valid, 1);
    repeat (10) @(posedge clk);
    #2;
    out_ready = 1'b1;
    log_q.delete();
    drain(100);
    check("t4_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_first", log_q[0].src, 1);
      check("t4_second", log_q[1].src, 3);
    end

    // Counter saturation
    mode[0] = 2; rem[0] = 260;
    drain(1200);
    check("t5_err_cnt_sat", err_cnt, 8'hFF);

    // Asynchronous reset during SEND
    out_ready = 1'b0;
    mode[2] = 0; rem[2] = 1;
    for (int n = 0; n < 50 && !out_valid; n++) @(posedge clk);
    check("t6_out_valid_seen", out_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid_async", out_valid, 0);
    check("t6_err_cnt_async", err_cnt, 0);
    check("t6_busy_async", busy, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    log_q.delete();
    for (int i = 0; i < NUM_SRC; i++) rem[i] = 1;
    drain(100);
    check("t6_count", log_q.size(), 4);
    if (log_q.size() > 0) check("t6_first_grant", log_q[0].src, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
